// File: rtl/ctrl_pipe_if.sv
// Decode-side handshake bundle: one decoded LC-3b instruction offered to the control pipeline.
interface ctrl_pipe_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode;
  logic       imm_bit;
  logic [2:0] dest;
  logic [2:0] src1;
  logic [2:0] src2;

  modport master (output in_valid, opcode, imm_bit, dest, src1, src2, input in_ready);
  modport slave  (input in_valid, opcode, imm_bit, dest, src1, src2, output in_ready);
endinterface

// File: rtl/ctrl_pipe.sv
// LC-3b decode-to-writeback control pipeline: decodes a control word and carries it through
// NUM_STAGES registered stages with load-use stall, memory-stage stall and branch flush.
module ctrl_pipe #(
  parameter int NUM_STAGES = 4,
  parameter int MEM_STAGE  = 1,
  parameter int CW_W       = 11
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ctrl_pipe_if.slave                 dec,
  input  logic                       mem_stall,
  input  logic                       flush,
  output logic                       illegal,
  output logic [NUM_STAGES-1:0]      stage_valid,
  output logic [NUM_STAGES*CW_W-1:0] stage_ctrl,
  output logic [NUM_STAGES*3-1:0]    stage_dest
);

  typedef enum logic [3:0] {
    OP_BR  = 4'b0000,
    OP_ADD = 4'b0001,
    OP_AND = 4'b0101,
    OP_LDR = 4'b0110,
    OP_STR = 4'b0111,
    OP_NOT = 4'b1001
  } opcode_e;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_AND = 2'b01, ALU_NOT = 2'b10, ALU_PASS = 2'b11} alu_e;

  typedef struct packed {
    logic       br_en;
    logic [1:0] addr2mux_sel;
    logic       addr1mux_sel;
    logic       mem_write;
    logic       mem_read;
    logic       load_cc;
    logic       load_regfile;
    logic       sr2mux_sel;
    alu_e       aluop;
  } cw_t;

  typedef struct packed {
    logic       valid;
    cw_t        cw;
    logic [2:0] dest;
  } slot_t;

  localparam slot_t BUBBLE = '0;

  slot_t stage_q [NUM_STAGES];
  slot_t stage_d [NUM_STAGES];
  logic  illegal_q, illegal_d;

  cw_t  dec_cw;
  logic src1_used, src2_used, op_known;
  logic hazard, accept;

  // NOTE: every signal gets a default at the top of an always_comb so no path leaves it
  // unassigned; a missing default is how latches get inferred.
  always_comb begin
    dec_cw    = '0;
    src1_used = 1'b0;
    src2_used = 1'b0;
    op_known  = 1'b1;
    case (dec.opcode)
      OP_ADD, OP_AND: begin
        dec_cw.aluop        = (dec.opcode == OP_AND) ? ALU_AND : ALU_ADD;
        dec_cw.sr2mux_sel   = dec.imm_bit;
        dec_cw.load_regfile = 1'b1;
        dec_cw.load_cc      = 1'b1;
        src1_used           = 1'b1;
        src2_used           = !dec.imm_bit;
      end
      OP_NOT: begin
        dec_cw.aluop        = ALU_NOT;
        dec_cw.load_regfile = 1'b1;
        dec_cw.load_cc      = 1'b1;
        src1_used           = 1'b1;
      end
      OP_LDR: begin
        dec_cw.aluop        = ALU_PASS;
        dec_cw.mem_read     = 1'b1;
        dec_cw.load_regfile = 1'b1;
        dec_cw.load_cc      = 1'b1;
        dec_cw.addr1mux_sel = 1'b1;
        dec_cw.addr2mux_sel = 2'b01;
        src1_used           = 1'b1;
      end
      OP_STR: begin
        dec_cw.aluop        = ALU_PASS;
        dec_cw.mem_write    = 1'b1;
        dec_cw.addr1mux_sel = 1'b1;
        dec_cw.addr2mux_sel = 2'b01;
        src1_used           = 1'b1;
        src2_used           = 1'b1;
      end
      OP_BR: begin
        dec_cw.br_en        = 1'b1;
        dec_cw.addr2mux_sel = 2'b10;
      end
      default: op_known = 1'b0;
    endcase
  end

  // A load sitting in stage 0 cannot forward its data to an instruction entering this cycle.
  assign hazard = stage_q[0].valid && stage_q[0].cw.mem_read &&
                  ((src1_used && (stage_q[0].dest == dec.src1)) ||
                   (src2_used && (stage_q[0].dest == dec.src2)));

  assign dec.in_ready = !hazard && !mem_stall && !flush;
  assign accept       = dec.in_valid && dec.in_ready;
  assign illegal_d    = accept && !op_known;

  always_comb begin
    stage_d = stage_q;
    if (accept) begin
      stage_d[0] = '{valid: 1'b1, cw: dec_cw, dest: dec.dest};
    end else if (flush || !mem_stall) begin
      stage_d[0] = BUBBLE;
    end
    // Stages up to the memory stage freeze on mem_stall; the one after it takes a bubble.
    for (int k = 1; k < NUM_STAGES; k++) begin
      if (k <= MEM_STAGE) begin
        if (!mem_stall) stage_d[k] = stage_q[k-1];
      end else if ((k == MEM_STAGE + 1) && mem_stall) begin
        stage_d[k] = BUBBLE;
      end else begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  // NOTE: these are pipeline registers, not a RAM, so every entry is cleared by the async
  // reset; all state updates here use non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_STAGES; k++) stage_q[k] <= BUBBLE;
      illegal_q <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_out
    assign stage_valid[k]               = stage_q[k].valid;
    assign stage_ctrl[k*CW_W +: CW_W]   = CW_W'(stage_q[k].cw);
    assign stage_dest[k*3 +: 3]         = stage_q[k].dest;
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios then random traffic against a
// table-driven reference model of the pipeline.
module tb_ctrl_pipe;
  localparam int NS = 4;
  localparam int MS = 1;
  localparam int CW = 11;

  logic clk, rst_n, mem_stall, flush, illegal;
  logic [NS-1:0]    stage_valid;
  logic [NS*CW-1:0] stage_ctrl;
  logic [NS*3-1:0]  stage_dest;

  ctrl_pipe_if dif ();

  ctrl_pipe #(.NUM_STAGES(NS), .MEM_STAGE(MS), .CW_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .dec(dif.slave), .mem_stall(mem_stall), .flush(flush),
    .illegal(illegal), .stage_valid(stage_valid), .stage_ctrl(stage_ctrl), .stage_dest(stage_dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {bit v; bit [10:0] c; bit [2:0] d;} mslot_t;
  mslot_t m [NS];
  bit     m_ill;
  int     n_checks = 0;
  int     n_fail   = 0;
  logic   last_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control words written out by hand from the field layout.
  function automatic bit [10:0] ref_cw(input bit [3:0] op, input bit imm);
    case (op)
      4'h1: return 11'h018 | (imm ? 11'h004 : 11'h000);
      4'h5: return 11'h019 | (imm ? 11'h004 : 11'h000);
      4'h9: return 11'h01A;
      4'h6: return 11'h1BB;
      4'h7: return 11'h1C3;
      4'h0: return 11'h600;
      default: return 11'h000;
    endcase
  endfunction

  function automatic bit ref_known(input bit [3:0] op);
    return op inside {4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'h9};
  endfunction

  function automatic bit ref_ready(input bit [3:0] op, input bit imm,
                                   input bit [2:0] s1, input bit [2:0] s2, input bit st, input bit fl);
    bit u1, u2, hz;
    u1 = op inside {4'h1, 4'h5, 4'h9, 4'h6, 4'h7};
    u2 = ((op == 4'h1 || op == 4'h5) && !imm) || op == 4'h7;
    hz = m[0].v && (m[0].c == 11'h1BB) && ((u1 && m[0].d == s1) || (u2 && m[0].d == s2));
    return !hz && !st && !fl;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NS; k++) m[k] = '{0, 0, 0};
    m_ill = 0;
  endfunction

  // A stall freezes the first h stages (h = MS+1) and inserts a bubble right behind them;
  // everything else shifts by one.
  function automatic void model_edge(input bit v, input bit [3:0] op, input bit imm, input bit [2:0] d,
                                     input bit [2:0] s1, input bit [2:0] s2, input bit st, input bit fl);
    mslot_t n [NS];
    int h;
    bit acc;
    acc = v && ref_ready(op, imm, s1, s2, st, fl);
    h = st ? MS + 1 : 0;
    for (int k = 0; k < NS; k++) begin
      if (k < h)                  n[k] = m[k];
      else if (k == h && h > 0)   n[k] = '{0, 0, 0};
      else if (k > 0)             n[k] = m[k-1];
      else                        n[k] = acc ? '{1, ref_cw(op, imm), d} : '{0, 0, 0};
    end
    if (fl) n[0] = '{0, 0, 0};
    m = n;
    m_ill = acc && !ref_known(op);
  endfunction

  task automatic check_outputs(input string tag);
    logic [NS-1:0] ev; logic [NS*CW-1:0] ec; logic [NS*3-1:0] ed;
    for (int k = 0; k < NS; k++) begin
      ev[k] = m[k].v; ec[k*CW +: CW] = m[k].c; ed[k*3 +: 3] = m[k].d;
    end
    check({tag, ".valid"}, stage_valid, ev);
    check({tag, ".ctrl"}, stage_ctrl, ec);
    check({tag, ".dest"}, stage_dest, ed);
    check({tag, ".illegal"}, illegal, m_ill);
  endtask

  task automatic drive(input bit v, input bit [3:0] op, input bit imm, input bit [2:0] d,
                       input bit [2:0] s1, input bit [2:0] s2, input bit st, input bit fl);
    dif.in_valid = v; dif.opcode = op; dif.imm_bit = imm; dif.dest = d;
    dif.src1 = s1; dif.src2 = s2; mem_stall = st; flush = fl;
  endtask

  // One cycle starting just after a falling edge: check in_ready, clock, check the stages.
  task automatic step(input string tag, input bit v, input bit [3:0] op, input bit imm, input bit [2:0] d,
                      input bit [2:0] s1, input bit [2:0] s2, input bit st, input bit fl);
    drive(v, op, imm, d, s1, s2, st, fl);
    #1;
    last_ready = dif.in_ready;
    check({tag, ".in_ready"}, dif.in_ready, ref_ready(op, imm, s1, s2, st, fl));
    @(posedge clk);
    model_edge(v, op, imm, d, s1, s2, st, fl);
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 4'h0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic random_step(input string tag);
    bit [3:0] ops [8];
    ops = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'h9, 4'hF, 4'h3};
    step(tag, 1'($urandom_range(3, 0) != 0), ops[$urandom_range(7, 0)], 1'($urandom),
         3'($urandom_range(3, 0)), 3'($urandom_range(3, 0)), 3'($urandom_range(3, 0)),
         1'($urandom_range(4, 0) == 0), 1'($urandom_range(7, 0) == 0));
  endtask

  initial begin
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    check("reset.valid", stage_valid, '0);
    check("reset.ctrl", stage_ctrl, '0);
    check("reset.dest", stage_dest, '0);
    check("reset.illegal", illegal, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD r1,r2,#3 through to writeback
    step("add_imm", 1, 4'h1, 1, 3'd1, 3'd2, 3'd0, 0, 0);
    check("add_imm.s0_ctrl", stage_ctrl[10:0], 11'h01C);
    idle("add_idle1"); idle("add_idle2"); idle("add_idle3");
    check("add_imm.wb_valid", stage_valid[3], 1'b1);
    check("add_imm.wb_ctrl", stage_ctrl[43:33], 11'h01C);
    check("add_imm.wb_dest", stage_dest[11:9], 3'd1);

    // LDR r3 then dependent ADD r4,r3,r5
    step("ldr_r3", 1, 4'h6, 0, 3'd3, 3'd0, 3'd0, 0, 0);
    step("lu_stall", 1, 4'h1, 0, 3'd4, 3'd3, 3'd5, 0, 0);
    check("lu_stall.ready", last_ready, 1'b0);
    check("lu_stall.s0_bubble", stage_valid[0], 1'b0);
    step("lu_enter", 1, 4'h1, 0, 3'd4, 3'd3, 3'd5, 0, 0);
    check("lu_enter.ready", last_ready, 1'b1);
    check("lu_enter.s0_ctrl", stage_ctrl[10:0], 11'h018);

    // mem_stall for three cycles with a load in stage 1
    step("ms_ldr", 1, 4'h6, 0, 3'd6, 3'd0, 3'd0, 0, 0);
    idle("ms_move");
    for (int i = 0; i < 3; i++) begin
      step("ms_hold", 1, 4'h1, 1, 3'd2, 3'd7, 3'd0, 1, 0);
      check("ms_hold.ready", last_ready, 1'b0);
      check("ms_hold.s1_ctrl", stage_ctrl[21:11], 11'h1BB);
      check("ms_hold.s2_bubble", stage_valid[2], 1'b0);
    end
    idle("ms_release");
    check("ms_release.s2_ctrl", stage_ctrl[32:22], 11'h1BB);

    // flush together with mem_stall
    step("fl_not", 1, 4'h9, 0, 3'd1, 3'd2, 3'd0, 0, 0);
    step("fl_str", 1, 4'h7, 0, 3'd0, 3'd1, 3'd2, 0, 0);
    step("fl_stall", 1, 4'h1, 1, 3'd2, 3'd0, 3'd0, 1, 1);
    check("fl_stall.ready", last_ready, 1'b0);
    check("fl_stall.s0_clear", stage_valid[0], 1'b0);
    check("fl_stall.s1_held", stage_ctrl[21:11], 11'h01A);
    idle("fl_idle");

    // unknown opcode
    step("illegal", 1, 4'hF, 0, 3'd5, 3'd0, 3'd0, 0, 0);
    check("illegal.pulse", illegal, 1'b1);
    check("illegal.s0_valid", stage_valid[0], 1'b1);
    check("illegal.s0_ctrl", stage_ctrl[10:0], 11'h000);
    idle("ill_idle1");
    check("illegal.drop", illegal, 1'b0);
    idle("ill_idle2"); idle("ill_idle3");
    check("illegal.wb_valid", stage_valid[3], 1'b1);

    for (int i = 0; i < 400; i++) random_step("rand");

    // asynchronous reset in the middle of traffic
    drive(1, 4'h1, 0, 3'd1, 3'd1, 3'd1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst.valid", stage_valid, '0);
    check("midrst.ctrl", stage_ctrl, '0);
    check("midrst.dest", stage_dest, '0);
    check("midrst.illegal", illegal, 1'b0);
    check("midrst.in_ready", dif.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) random_step("rand_post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
